// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, FSM encoding and flag layout for the ALU opcode sequencer
package alu_pkg;

  localparam int ALU_DW  = 4;
  localparam int ALU_OPW = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } seq_state_e;

  // Flag bit positions inside a result-buffer entry {out, z, c, v, p}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_P = 0;

  localparam logic [ALU_OPW-1:0] OP_ADD = 4'h0;
  localparam logic [ALU_OPW-1:0] OP_SUB = 4'h1;
  localparam logic [ALU_OPW-1:0] OP_AND = 4'h2;
  localparam logic [ALU_OPW-1:0] OP_OR  = 4'h3;
  localparam logic [ALU_OPW-1:0] OP_XOR = 4'h4;

endpackage

// File: rtl/alu_result_buf.sv
// rtl/alu_result_buf.sv - 2**OPW-entry result register file, one write port, one registered read port
module alu_result_buf #(
  parameter int DW  = 4,
  parameter int OPW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [OPW-1:0]  waddr,
  input  logic [DW+3:0]   wdata,
  input  logic [OPW-1:0]  rd_addr,
  output logic [DW+3:0]   rd_data
);

  logic [DW+3:0] mem [2**OPW];

  // Storage is never reset; the sequencer's valid_mask says which entries mean anything
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-edge read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - clocked opcode sweep driver for ALU_4bit with per-opcode result capture
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DW  = ALU_DW,
  parameter int OPW = ALU_OPW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DW-1:0]     op_a,
  input  logic [DW-1:0]     op_b,
  input  logic [OPW-1:0]    op_first,
  input  logic [OPW-1:0]    op_last,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [OPW-1:0]    alu_opcode,
  input  logic [DW-1:0]     alu_out,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_p,
  input  logic [OPW-1:0]    rd_addr,
  output logic [DW+3:0]     rd_data,
  output logic [2**OPW-1:0] valid_mask
);

  seq_state_e     state_q, state_d;
  logic [DW-1:0]  a_lat, b_lat;
  logic [OPW-1:0] cur_op, last_lat;
  logic           buf_we;
  logic [DW+3:0]  buf_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_lat      <= '0;
      b_lat      <= '0;
      cur_op     <= '0;
      last_lat   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      valid_mask <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_lat      <= op_a;
            b_lat      <= op_b;
            cur_op     <= op_first;
            last_lat   <= op_last;
            valid_mask <= '0;
          end
        end
        ST_ISSUE: begin
          alu_a      <= a_lat;
          alu_b      <= b_lat;
          alu_opcode <= cur_op;
        end
        ST_CAPTURE: begin
          valid_mask[cur_op] <= 1'b1;
          // Increment wraps naturally, giving the 15 -> 0 sweep when op_first > op_last
          if (cur_op != last_lat) begin
            cur_op <= cur_op + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    buf_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy    = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy    = 1'b1;
        buf_we  = 1'b1;
        state_d = (cur_op == last_lat) ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    buf_wdata         = '0;
    buf_wdata[DW+3:4] = alu_out;
    buf_wdata[FLAG_Z] = alu_z;
    buf_wdata[FLAG_C] = alu_c;
    buf_wdata[FLAG_V] = alu_v;
    buf_wdata[FLAG_P] = alu_p;
  end

  alu_result_buf #(
    .DW  (DW),
    .OPW (OPW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (buf_we),
    .waddr   (cur_op),
    .wdata   (buf_wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential driver for the 4-bit ALU datapath. On a start request it latches one operand pair and steps the ALU opcode through a programmable range.
- For each opcode it captures the ALU result and the Z/C/V/P flags into a 16-entry result buffer indexed by opcode. The buffer is readable through a registered read port.
- Sits in front of ALU_4bit. It replaces open-loop stimulus with a self-running, clocked opcode sweep for on-chip self-test.

Parameters:
- DW, 4, operand/result width (A, B, Out).
- OPW, 4, opcode width; buffer depth = 2**OPW.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- op_a  in  DW  operand A, latched on accepted start.
- op_b  in  DW  operand B, latched on accepted start.
- op_first  in  OPW  first opcode of sweep, latched on accepted start.
- op_last  in  OPW  last opcode of sweep, latched on accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last capture completes.
- alu_a  out  DW  registered operand A to ALU.
- alu_b  out  DW  registered operand B to ALU.
- alu_opcode  out  OPW  registered opcode to ALU.
- alu_out  in  DW  ALU result (combinational from alu_a/alu_b/alu_opcode).
- alu_z, alu_c, alu_v, alu_p  in  1 each  ALU flags.
- rd_addr  in  OPW  buffer read index (opcode).
- rd_data  out  DW+4  {Out, Z, C, V, P} for rd_addr, 1-cycle registered latency.
- valid_mask  out  2**OPW  bit k set when the entry for opcode k was written in the current or last sweep.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state returns to IDLE; busy=0, done=0.
  - alu_a=0, alu_b=0, alu_opcode=0, rd_data=0, valid_mask=0.
  - Buffer storage is not cleared; valid_mask gates it.
  - Reset mid-sweep aborts immediately; no done pulse.
- FSM states are IDLE, ISSUE, CAPTURE, FINISH.
- IDLE:
  - If start=1, latch op_a, op_b, op_first, op_last; load cur_op=op_first; clear valid_mask; go to ISSUE.
  - start while not IDLE is ignored, with no queuing.
- ISSUE:
  - Drive alu_a=A_lat, alu_b=B_lat, alu_opcode=cur_op (registered, so valid in the next cycle).
  - Go to CAPTURE.
- CAPTURE:
  - ALU inputs are now stable.
  - Write buf[cur_op] <= {alu_out, alu_z, alu_c, alu_v, alu_p}; set valid_mask[cur_op].
  - If cur_op==op_last_lat, go to FINISH. Otherwise cur_op <= cur_op+1 (mod 2**OPW) and go to ISSUE.
- FINISH: done=1 for exactly one cycle; busy=0 in the same cycle; go to IDLE.
- Timing:
  - Each opcode costs 2 cycles.
  - Sweep length N = ((op_last - op_first) mod 2**OPW) + 1.
  - done is asserted 2N+1 cycles after the start-accept edge.
- Range boundaries:
  - Wrap-around: op_first > op_last sweeps through 15 -> 0 (e.g. 14,15,0,1).
  - op_first == op_last gives a single-op sweep.
  - The full range 0..15 gives N=16.
- Read port:
  - rd_data <= buf[rd_addr] every cycle, independent of state.
  - A read of an address written in the same cycle returns the old contents (read-before-write).
- alu_a/alu_b/alu_opcode hold their last values in IDLE and FINISH.

Decomposition:
- Shared package alu_pkg:
  - DW=4 and OPW=4 constants.
  - FSM state encoding (2 bits).
  - Flag bit positions within rd_data (Z=3, C=2, V=1, P=0).
  - Opcode localparams shared with ALU_4bit.
- One natural sub-module: alu_result_buf. It is a 16 x 8 register file with one write port and one registered read port.
- FSM and counter stay in the top.

Test Plan:
Bench ALU model: Out=(A+opcode) mod 16, C=carry-out, Z=(Out==0), V=0, P=^Out.
- Full sweep: rst_n=0 for 2 cycles; op_a=5, op_b=12, op_first=0, op_last=15, start pulse.
  - Required: busy for 32 cycles; done at cycle 33; valid_mask=16'hFFFF.
  - rd_addr=3 gives rd_data={8, Z0, C0, V0, P1}.
  - rd_addr=11 gives rd_data={0, Z1, C1, V0, P0}.
- Wrap range: op_first=14, op_last=1, op_a=5.
  - Required: alu_opcode sequence 14,15,0,1; done 9 cycles after accept; valid_mask=16'hC003.
- Single op: op_first=op_last=7.
  - Required: done 3 cycles after accept; valid_mask=16'h0080.
  - rd_data for address 7 is {12, 0, 0, 0, 0}.
- Start while busy: second start pulse 4 cycles into the full sweep with op_a=0.
  - Required: ignored; results still reflect op_a=5; exactly one done pulse.
- Reset mid-sweep: rst_n=0 at cycle 10 of the full sweep.
  - Required: next cycle busy=0, done never pulses, valid_mask=0, alu_opcode=0.
  - A fresh start then completes normally.
- Read latency: rd_addr changes 3 -> 11 in IDLE after the full sweep.
  - Required: rd_data updates exactly one clk later.
